// File: rtl/dclk_sequencer.sv
// dclk_sequencer: bursts Cycles serial-clock periods, shifts in ADC data
// and issues clear/increment opcodes to the downstream dclk counter.
module dclk_sequencer #(
  parameter int Cycles    = 25,
  parameter int Div       = 4,
  parameter int DataWidth = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 sdi_i,
  output logic                 dclk_o,
  output logic [1:0]           opc_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  localparam logic [7:0] DivLast = 8'(Div - 1);
  localparam logic [7:0] NumCyc  = 8'(Cycles);
  localparam logic [1:0] OpcHold = 2'b00;
  localparam logic [1:0] OpcInc  = 2'b01;
  localparam logic [1:0] OpcClr  = 2'b10;

  state_t               r_state;
  state_t               w_state_n;
  logic [7:0]           r_div;
  logic [7:0]           w_div_n;
  logic [7:0]           r_bit;
  logic [7:0]           w_bit_n;
  logic [DataWidth-1:0] r_sh;
  logic [DataWidth-1:0] w_sh_n;
  logic [DataWidth-1:0] r_data;
  logic [DataWidth-1:0] w_data_n;
  logic                 r_dclk;
  logic                 w_dclk_n;
  logic [1:0]           r_opc;
  logic [1:0]           w_opc_n;
  logic                 r_busy;
  logic                 w_busy_n;
  logic                 r_done;
  logic                 w_done_n;
  logic                 w_div_end;

  assign w_div_end = (r_div == DivLast);

  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_bit_n   = r_bit;
    w_sh_n    = r_sh;
    w_data_n  = r_data;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_state_n = S_LOAD;
      end
      S_LOAD: begin
        w_div_n   = '0;
        w_bit_n   = '0;
        w_sh_n    = '0;
        w_state_n = S_HIGH;
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_sh_n    = {r_sh[DataWidth-2:0], sdi_i};
          w_bit_n   = r_bit + 8'd1;
          w_div_n   = '0;
          w_state_n = S_LOW;
        end else begin
          w_div_n = r_div + 8'd1;
        end
      end
      S_LOW: begin
        if (w_div_end) begin
          w_div_n = '0;
          if (r_bit < NumCyc) begin
            w_state_n = S_HIGH;
          end else begin
            w_state_n = S_DONE;
            w_data_n  = r_sh;
          end
        end else begin
          w_div_n = r_div + 8'd1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops present them
  // in the same cycle the state register does.
  always_comb begin
    w_dclk_n = 1'b0;
    w_opc_n  = OpcHold;
    w_busy_n = 1'b0;
    w_done_n = 1'b0;
    unique case (w_state_n)
      S_LOAD: begin
        w_opc_n  = OpcClr;
        w_busy_n = 1'b1;
      end
      S_HIGH: begin
        w_dclk_n = 1'b1;
        w_busy_n = 1'b1;
        if (w_div_n == 8'd0) w_opc_n = OpcInc;
      end
      S_LOW: begin
        w_busy_n = 1'b1;
      end
      S_DONE: begin
        w_done_n = 1'b1;
      end
      default: begin
        w_opc_n = OpcHold;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_dclk  <= 1'b0;
      r_opc   <= OpcHold;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_sh    <= w_sh_n;
      r_data  <= w_data_n;
      r_dclk  <= w_dclk_n;
      r_opc   <= w_opc_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign dclk_o = r_dclk;
  assign opc_o  = r_opc;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign data_o = r_data;

endmodule

// File: doc/dclk_sequencer.md
Name: dclk_sequencer

Overview:
- Upstream control stage for the dclk cycle counter.
- On a start request, emits one burst of exactly Cycles serial-clock periods on dclk_o and shifts in the ADC serial data line.
- Drives the 2-bit opcode bus that the downstream counter consumes: 10 = clear, 01 = increment, 00 = hold.
- Presents the captured conversion word with a one-cycle done pulse.

Parameters:
- Cycles, 25, number of dclk periods per burst (>= DataWidth, <= 255).
- Div, 4, clk_i cycles per dclk half-period (>= 1, <= 255).
- DataWidth, 24, width of the captured data word.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  burst request; sampled only in IDLE.
- sdi_i  in  1  ADC serial data, MSB first.
- dclk_o  out  1  serial clock to ADC; idles low.
- opc_o  out  2  opcode to the downstream counter.
- busy_o  out  1  high from LOAD through the last LOW phase.
- done_o  out  1  one-cycle pulse when data_o is updated.
- data_o  out  DataWidth  last captured word; held between bursts.

Behaviour:
- Reset: synchronous to clk_i, active-high. While rst_i=1 at a clock edge, all state returns to reset values and rst_i overrides all other inputs.
  - Reset values: state=IDLE, dclk_o=0, opc_o=00, busy_o=0, done_o=0, data_o=0, shift register=0, internal counters=0.
  - Reset mid-burst aborts immediately. No done_o pulse; data_o returns to 0.
- All outputs are registered, decoded from state, and glitch-free.
- States:
  - IDLE: dclk_o=0, opc_o=00. If start_i=1, go to LOAD.
  - LOAD (1 cycle): opc_o=10 (clear downstream counter), busy_o=1. Clear bit counter and shift register. Go to HIGH.
  - HIGH (Div cycles): dclk_o=1.
    - opc_o=01 in the first cycle of HIGH only; 00 otherwise.
    - On the last cycle of HIGH, shift sdi_i into the LSB of the shift register (left shift, MSB first) and increment the bit counter. Then go to LOW.
  - LOW (Div cycles): dclk_o=0, opc_o=00. On the last cycle, go to HIGH if bit counter < Cycles, else go to DONE.
  - DONE (1 cycle): busy_o=0, done_o=1, opc_o=00. data_o loads the lower DataWidth bits of the shift register, so the first Cycles-DataWidth samples are discarded. Go to IDLE.
- Latency:
  - start_i accepted at edge k gives LOAD in cycle k+1 and the first dclk_o high in cycle k+2.
  - done_o goes high 2 + 2*Div*Cycles cycles after acceptance.
- Each burst produces exactly Cycles opc_o=01 pulses, each 1 clk_i wide, one per dclk_o rising edge.
- start_i is ignored outside IDLE, including in DONE. It is level-sampled: if held high, a new burst starts on the cycle after DONE.
- With Div=1, HIGH and LOW are each 1 cycle; opc_o=01 and the sample then occur in the same cycle.
- Internal counter widths are 8 bits; parameters are bounded so counters never wrap.

Test Plan:
- Reset values: assert rst_i for 3 cycles mid-idle -> every output holds its reset value (dclk_o=0, opc_o=00, busy_o=0, done_o=0, data_o=0).
- Basic burst (Div=2, Cycles=25, DataWidth=24): pulse start_i; sdi_i drives bit 0 then 0xA5C3F1 MSB first.
  - dclk_o shows 25 high pulses of 2 cycles each.
  - opc_o shows one 10, then 25 single-cycle 01 pulses.
  - done_o pulses exactly 102 cycles after start is accepted, with data_o=0xA5C3F1.
- Start while busy: reassert start_i during HIGH and during DONE -> no extra LOAD; the burst count stays 25.
- Back-to-back: hold start_i high (Div=1) -> the second LOAD follows DONE by exactly one IDLE cycle. data_o holds the first word until the second done_o.
- Reset mid-burst: assert rst_i after the 10th dclk_o rising edge -> outputs return to reset values on the next edge, with no done_o. A following start_i runs a full 25-cycle burst.
- Data hold: with all-ones sdi_i for one burst and idle afterwards -> data_o=0xFFFFFF and stays stable for 50 cycles with no further opc_o activity.
